dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the core's data interface.
- The core drives the data address (DAD), the store data (DDT) and the access control. This block answers with load data (ReadDDT) and a completion pulse.
- Owns a byte-addressable word RAM with byte/halfword/word lanes and programmable wait states.
- The core's load-wait logic stalls the PC and register write until `ready`.

Parameters:
- ADDR_WIDTH, 12: byte-address bits decoded; RAM depth = 2^(ADDR_WIDTH-2) words.
- WAIT_CYCLES, 1: wait-state cycles between acceptance and completion; legal 0..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- req  input  1  access request (load or store)
- we  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- unsigned_ld  input  1  1 = zero-extend load (lbu/lhu), 0 = sign-extend
- dad  input  32  byte address
- ddt  input  32  store data, LSB-aligned
- read_ddt  output  32  load result, extended to 32 bits
- ready  output  1  one-cycle completion pulse
- busy  output  1  access in progress
- misalign  output  1  error flag, valid with `ready`

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high on `rst`; all state updates on the rising edge of `clk`.
- Reset values: state IDLE, wait counter 0, `read_ddt` = 0, `ready` = 0, `busy` = 0, `misalign` = 0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, DONE. `busy` = (state != IDLE).
- IDLE:
  - If `req` = 1, latch `we`, `size`, `unsigned_ld`, `dad`, `ddt`; this is acceptance cycle T.
  - Next state is WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES > 0, else DONE.
- WAIT: decrement the counter; go to DONE when the counter is 0.
- DONE: `ready` = 1 for exactly this cycle; next state is IDLE.
- Latency: `ready` is asserted in cycle T+WAIT_CYCLES+1.
- Back-to-back requests: a `req` during WAIT or DONE is ignored, with no queueing. The earliest next acceptance is the cycle after DONE.
- Misalignment is checked on the latched request. It is misaligned if any of these hold:
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size = 11.
- On a misaligned access:
  - the block runs the same wait sequence;
  - in DONE, `misalign` = 1 with `ready`;
  - no RAM write occurs;
  - `read_ddt` is unchanged.
- `misalign` is 0 at all other times.
- Word index = addr[ADDR_WIDTH-1:2]. Bits above ADDR_WIDTH are ignored, so addresses alias (wrap) modulo 2^ADDR_WIDTH.
- Store lanes:
  - byte: `ddt[7:0]` goes to lane addr[1:0];
  - halfword: `ddt[15:0]` goes to lanes {addr[1],0} and {addr[1],1};
  - word: all four lanes.
  - Unaddressed lanes keep their old value.
- A store commits at the rising edge that ends DONE. A load issued after `ready` sees the new data.
- Load:
  - The RAM is read on the latched address; the extended result is registered into `read_ddt` at the edge entering DONE.
  - `read_ddt` is valid while `ready` = 1 and holds until the next successful load completes.
  - Stores do not change `read_ddt`.
- Load extension:
  - byte: bit 7 is replicated to bits 31:8, or zeros if `unsigned_ld` = 1;
  - halfword: bit 15 is replicated to bits 31:16, or zeros if `unsigned_ld` = 1;
  - word: `unsigned_ld` is ignored.
- Little-endian: lane 0 = bits 7:0.
- Reset mid-operation:
  - return to IDLE and zero all outputs;
  - a pending store is discarded (no RAM write);
  - a pending load produces no `ready`.
- `req` asserted in the same cycle as `rst`: reset wins; the request is not accepted.
- Input stability: inputs are sampled only at acceptance, so changes while `busy` have no effect.

Test Plan:
- WAIT_CYCLES = 1: store word 0xDEADBEEF to 0x010, then load word from 0x010 -> `ready` 2 cycles after each acceptance, `read_ddt` = 0xDEADBEEF, `misalign` = 0.
- Store bytes 0x80, 0x11, 0x22, 0x7F to 0x020..0x023:
  - load word 0x020 -> 0x7F221180;
  - lb 0x020 -> 0xFFFFFF80;
  - lbu 0x020 -> 0x00000080;
  - lh 0x022 -> 0x00007F22.
- Half store 0xBEEF to 0x032 over word 0x11111111 -> word 0xBEEF1111; lh 0x032 -> 0xFFFFBEEF; lhu 0x032 -> 0x0000BEEF.
- Misaligned cases:
  - lw 0x005 -> `ready` = 1 with `misalign` = 1, `read_ddt` unchanged;
  - sh 0x031 -> memory unchanged on readback;
  - size = 11 -> `misalign` = 1.
- `req` held high continuously with different addresses -> only one acceptance per WAIT/DONE sequence, `busy` high throughout; WAIT_CYCLES = 0 gives `ready` at T+1, WAIT_CYCLES = 3 gives it at T+4.
- Reset and aliasing:
  - assert `rst` during WAIT of a store 0x12345678 to 0x040 -> outputs 0 next cycle, no `ready`, later load of 0x040 returns the old value;
  - with ADDR_WIDTH = 12, load from 0x1040 returns the same data as 0x040.

Source files
------------

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: byte-lane word RAM with
// programmable wait states, load extension and misalignment reporting.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] dad,
    input  logic [31:0] ddt,
    output logic [31:0] read_ddt,
    output logic        ready,
    output logic        busy,
    output logic        misalign
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic                    we_reg;
    logic [1:0]              size_reg;
    logic                    uns_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [31:0]             ddt_reg;
    logic [31:0]             read_ddt_reg;
    logic                    ready_reg;
    logic                    misalign_reg;

    // Upper address bits alias onto the decoded range.
    logic unused_dad_bits;
    assign unused_dad_bits = ^dad[31:ADDR_WIDTH];

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = a[0];
            2'b10:   is_misaligned = (a != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: extend = w;
        endcase
    endfunction

    // When WAIT_CYCLES is 0 the request completes straight from IDLE, so the
    // completion datapath must look at the live inputs rather than the latches.
    logic                  sel_in;
    logic                  cur_we;
    logic                  cur_uns;
    logic [1:0]            cur_size;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_mis;
    logic                  finish;

    assign sel_in   = (state_reg == ST_IDLE);
    assign cur_we   = sel_in ? we          : we_reg;
    assign cur_uns  = sel_in ? unsigned_ld : uns_reg;
    assign cur_size = sel_in ? size        : size_reg;
    assign cur_addr = sel_in ? dad[ADDR_WIDTH-1:0] : addr_reg;
    assign cur_mis  = is_misaligned(cur_size, cur_addr[1:0]);
    assign finish   = ((state_reg == ST_IDLE) && req && (WAIT_CYCLES == 0)) ||
                      ((state_reg == ST_WAIT) && (cnt_reg == 4'd0));

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       lane_rdata [4];
    logic [31:0]      rd_word;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic             wr_en;

    assign rd_idx  = cur_addr[ADDR_WIDTH-1:2];
    assign wr_idx  = addr_reg[ADDR_WIDTH-1:2];
    assign rd_word = {lane_rdata[3], lane_rdata[2], lane_rdata[1], lane_rdata[0]};
    // Store commits on the edge leaving DONE; a reset in that cycle cancels it.
    assign wr_en   = (state_reg == ST_DONE) && we_reg && !misalign_reg && !rst;

    always_comb begin
        be    = 4'b0000;
        wdata = ddt_reg;
        case (size_reg)
            2'b00: begin
                be    = 4'b0001 << addr_reg[1:0];
                wdata = {4{ddt_reg[7:0]}};
            end
            2'b01: begin
                be    = addr_reg[1] ? 4'b1100 : 4'b0011;
                wdata = {2{ddt_reg[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en && be[gi]) begin
                    lane_mem[wr_idx] <= wdata[8*gi +: 8];
                end
            end

            assign lane_rdata[gi] = lane_mem[rd_idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            uns_reg      <= 1'b0;
            addr_reg     <= '0;
            ddt_reg      <= 32'd0;
            read_ddt_reg <= 32'd0;
            ready_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            ready_reg    <= 1'b0;
            misalign_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        we_reg   <= we;
                        size_reg <= size;
                        uns_reg  <= unsigned_ld;
                        addr_reg <= dad[ADDR_WIDTH-1:0];
                        ddt_reg  <= ddt;
                        if (WAIT_CYCLES == 0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase

            if (finish) begin
                ready_reg    <= 1'b1;
                misalign_reg <= cur_mis;
                if (!cur_we && !cur_mis) begin
                    read_ddt_reg <= extend(rd_word, cur_addr[1:0], cur_size, cur_uns);
                end
            end
        end
    end

    assign read_ddt = read_ddt_reg;
    assign ready    = ready_reg;
    assign misalign = misalign_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances cover 0, 1 and 3 wait states.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req1 = 1'b0, req0 = 1'b0, req3 = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        unsigned_ld = 1'b0;
    logic [31:0] dad = 32'd0;
    logic [31:0] ddt = 32'd0;

    logic [31:0] rd1, rd0, rd3;
    logic        rdy1, rdy0, rdy3;
    logic        busy1, busy0, busy3;
    logic        mis1, mis0, mis3;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req1), .we(we), .size(size), .unsigned_ld(unsigned_ld),
        .dad(dad), .ddt(ddt), .read_ddt(rd1), .ready(rdy1), .busy(busy1), .misalign(mis1));

    dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .size(size), .unsigned_ld(unsigned_ld),
        .dad(dad), .ddt(ddt), .read_ddt(rd0), .ready(rdy0), .busy(busy0), .misalign(mis0));

    dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .size(size), .unsigned_ld(unsigned_ld),
        .dad(dad), .ddt(ddt), .read_ddt(rd3), .ready(rdy3), .busy(busy3), .misalign(mis3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int which, input logic v);
        case (which)
            0:       req0 = v;
            3:       req3 = v;
            default: req1 = v;
        endcase
    endtask

    task automatic sample(input int which, output logic [31:0] rd, output logic rdy, output logic mis);
        case (which)
            0:       begin rd = rd0; rdy = rdy0; mis = mis0; end
            3:       begin rd = rd3; rdy = rdy3; mis = mis3; end
            default: begin rd = rd1; rdy = rdy1; mis = mis1; end
        endcase
    endtask

    // One transaction: drive at a falling edge, count cycles until ready.
    task automatic access(input int which, input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic mis, output int lat);
        logic rdy;
        @(negedge clk);
        we = w; size = sz; unsigned_ld = uns; dad = a; ddt = d;
        set_req(which, 1'b1);
        @(posedge clk);
        #1 set_req(which, 1'b0);
        lat = 0;
        rdy = 1'b0;
        rd  = 32'd0;
        mis = 1'b0;
        while (!rdy && lat < 20) begin
            @(negedge clk);
            lat++;
            sample(which, rd, rdy, mis);
        end
        if (!rdy) lat = -1;
        $display("[TB] dut_w%0d %s size=%0d uns=%0d addr=%h ddt=%h -> read_ddt=%h misalign=%b latency=%0d",
                 which, w ? "store" : "load ", sz, uns, a, d, rd, mis, lat);
    endtask

    task automatic xfer(input string tag, input int which, input logic w, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_mis, input logic chk_rd, input logic [31:0] exp_rd);
        logic [31:0] rd;
        logic        mis;
        int          lat;
        access(which, w, sz, uns, a, d, rd, mis, lat);
        check({tag, ".lat"}, 32'(lat), 32'(which + 1));
        check({tag, ".mis"}, {31'd0, mis}, {31'd0, exp_mis});
        if (chk_rd) check({tag, ".rd"}, rd, exp_rd);
    endtask

    initial begin
        logic [5:0]  rpat, bpat;
        logic [31:0] rd_a, rd_b;
        int          cnt;

        repeat (3) @(negedge clk);
        check("rst.ready", {31'd0, rdy1}, 32'd0);
        check("rst.busy",  {31'd0, busy1}, 32'd0);
        check("rst.mis",   {31'd0, mis1}, 32'd0);
        check("rst.rd",    rd1, 32'd0);
        rst = 1'b0;

        // Word store / load round trip
        xfer("sw10", 1, 1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 0, 0, 32'd0);
        xfer("lw10", 1, 0, 2'b10, 0, 32'h010, 32'd0, 0, 1, 32'hDEADBEEF);

        // Byte lanes and extension
        xfer("sb20", 1, 1, 2'b00, 0, 32'h020, 32'h00000080, 0, 0, 32'd0);
        xfer("sb21", 1, 1, 2'b00, 0, 32'h021, 32'hFFFFFF11, 0, 0, 32'd0);
        xfer("sb22", 1, 1, 2'b00, 0, 32'h022, 32'h00000022, 0, 0, 32'd0);
        xfer("sb23", 1, 1, 2'b00, 0, 32'h023, 32'hAAAAAA7F, 0, 0, 32'd0);
        xfer("lw20",  1, 0, 2'b10, 0, 32'h020, 32'd0, 0, 1, 32'h7F221180);
        xfer("lb20",  1, 0, 2'b00, 0, 32'h020, 32'd0, 0, 1, 32'hFFFFFF80);
        xfer("lbu20", 1, 0, 2'b00, 1, 32'h020, 32'd0, 0, 1, 32'h00000080);
        xfer("lh22",  1, 0, 2'b01, 0, 32'h022, 32'd0, 0, 1, 32'h00007F22);

        // Halfword lanes
        xfer("sw30",  1, 1, 2'b10, 0, 32'h030, 32'h11111111, 0, 0, 32'd0);
        xfer("sh32",  1, 1, 2'b01, 0, 32'h032, 32'h1234BEEF, 0, 0, 32'd0);
        xfer("lw30",  1, 0, 2'b10, 0, 32'h030, 32'd0, 0, 1, 32'hBEEF1111);
        xfer("lh32",  1, 0, 2'b01, 0, 32'h032, 32'd0, 0, 1, 32'hFFFFBEEF);
        xfer("lhu32", 1, 0, 2'b01, 1, 32'h032, 32'd0, 0, 1, 32'h0000BEEF);

        // Misaligned accesses: flagged, no write, read_ddt held
        xfer("lw05",  1, 0, 2'b10, 0, 32'h005, 32'd0, 1, 1, 32'h0000BEEF);
        @(negedge clk);
        check("mis.clear", {31'd0, mis1}, 32'd0);
        xfer("sh31",  1, 1, 2'b01, 0, 32'h031, 32'h0000AAAA, 1, 0, 32'd0);
        xfer("lw30b", 1, 0, 2'b10, 0, 32'h030, 32'd0, 0, 1, 32'hBEEF1111);
        xfer("sz11",  1, 0, 2'b11, 0, 32'h030, 32'd0, 1, 1, 32'hBEEF1111);

        // Latency with 0 and 3 wait states
        xfer("w0.sw", 0, 1, 2'b10, 0, 32'h060, 32'h55AA33CC, 0, 0, 32'd0);
        xfer("w0.lw", 0, 0, 2'b10, 0, 32'h060, 32'd0, 0, 1, 32'h55AA33CC);
        xfer("w3.sw", 3, 1, 2'b10, 0, 32'h060, 32'hA5A5C3C3, 0, 0, 32'd0);
        xfer("w3.lb", 3, 0, 2'b00, 0, 32'h061, 32'd0, 0, 1, 32'hFFFFFFC3);

        // req held high: one acceptance per sequence, inputs ignored while busy
        @(negedge clk);
        we = 1'b0; size = 2'b10; unsigned_ld = 1'b0; dad = 32'h010; req1 = 1'b1;
        @(posedge clk);
        rpat = '0; bpat = '0; rd_a = '0; rd_b = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rpat[k-1] = rdy1;
            bpat[k-1] = busy1;
            if (k == 2) rd_a = rd1;
            if (k == 5) rd_b = rd1;
            dad = (k == 3) ? 32'h020 : 32'h030;
            if (k == 6) req1 = 1'b0;
        end
        $display("[TB] held req: ready=%b busy=%b rd_a=%h rd_b=%h", rpat, bpat, rd_a, rd_b);
        check("hold.ready", {26'd0, rpat}, {26'd0, 6'b010010});
        check("hold.busy",  {26'd0, bpat}, {26'd0, 6'b011011});
        check("hold.rd_a",  rd_a, 32'hDEADBEEF);
        check("hold.rd_b",  rd_b, 32'h7F221180);

        // Reset during WAIT of a store
        xfer("sw40", 1, 1, 2'b10, 0, 32'h040, 32'hCAFEF00D, 0, 0, 32'd0);
        @(negedge clk);
        we = 1'b1; size = 2'b10; dad = 32'h040; ddt = 32'h12345678; req1 = 1'b1;
        @(posedge clk);
        #1 req1 = 1'b0;
        @(negedge clk);
        check("mid.busy", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid.ready", {31'd0, rdy1}, 32'd0);
        check("mid.busy0", {31'd0, busy1}, 32'd0);
        check("mid.mis",   {31'd0, mis1}, 32'd0);
        check("mid.rd",    rd1, 32'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            cnt += int'(rdy1);
        end
        check("mid.noready", 32'(cnt), 32'd0);
        $display("[TB] reset during store wait: readies afterwards=%0d", cnt);
        xfer("lw40", 1, 0, 2'b10, 0, 32'h040, 32'd0, 0, 1, 32'hCAFEF00D);

        // req together with rst is not accepted
        @(negedge clk);
        rst = 1'b1; req1 = 1'b1; we = 1'b0; dad = 32'h040;
        @(negedge clk);
        check("rstreq.busy", {31'd0, busy1}, 32'd0);
        rst = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("rstreq.busy2",  {31'd0, busy1}, 32'd0);
        check("rstreq.ready",  {31'd0, rdy1}, 32'd0);
        $display("[TB] req with rst: busy=%b ready=%b", busy1, rdy1);

        // Address aliasing above ADDR_WIDTH
        xfer("lw1040", 1, 0, 2'b10, 0, 32'h1040, 32'd0, 0, 1, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
